// File: rtl/p405s_icu_dp_regpipe.sv
// DEPTH-stage valid-tagged datapath register pipe between ICU fetch capture and the
// instruction buffer; empty stages collapse forward while the output is held.
module p405s_icu_dp_regpipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNTW  = 4
) (
    input  logic             CB,
    input  logic             RSTL,
    input  logic [0:WIDTH-1] D,
    input  logic             E1,
    output logic             IN_RDY,
    input  logic             HOLD,
    input  logic             FLUSH,
    output logic [0:WIDTH-1] L2,
    output logic             L2_VLD,
    output logic [0:CNTW-1]  CNT
);

    localparam int unsigned LAST = DEPTH - 1;

    logic [0:WIDTH-1] r_d [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [0:CNTW-1]  r_cnt;

    logic [DEPTH-1:0] w_acc;
    logic [DEPTH-1:0] w_in_v;
    logic [0:WIDTH-1] w_in_d [DEPTH];
    logic [DEPTH-1:0] w_nxt_v;
    logic [0:WIDTH-1] w_nxt_d [DEPTH];
    logic             w_ret;
    logic             w_wr;

    // Stage k can load iff the tail can drain or some stage at or beyond k is empty.
    for (genvar k = 0; k < DEPTH; k++) begin : g_acc
        assign w_acc[k] = ~HOLD | ~(&r_v[LAST:k]);
    end

    assign w_ret  = r_v[LAST] & ~HOLD;
    assign IN_RDY = w_acc[0] & ~FLUSH;
    assign w_wr   = E1 & IN_RDY;

    assign w_in_v[0] = w_wr;
    assign w_in_d[0] = D;
    for (genvar k = 1; k < DEPTH; k++) begin : g_in
        assign w_in_v[k] = r_v[k-1];
        assign w_in_d[k] = r_d[k-1];
    end

    // Data load is gated by the incoming valid so an empty stage always holds zero.
    for (genvar k = 0; k < DEPTH; k++) begin : g_nxt
        assign w_nxt_v[k] = w_acc[k] ? w_in_v[k] : r_v[k];
        assign w_nxt_d[k] = w_acc[k] ? (w_in_v[k] ? w_in_d[k] : '0) : r_d[k];
    end

    always_ff @(posedge CB) begin
        if (!RSTL || FLUSH) begin
            r_v   <= '0;
            r_d   <= '{default: '0};
            r_cnt <= '0;
        end else begin
            r_v   <= w_nxt_v;
            r_d   <= w_nxt_d;
            r_cnt <= r_cnt + CNTW'(w_wr) - CNTW'(w_ret);
        end
    end

    assign L2     = r_d[LAST];
    assign L2_VLD = r_v[LAST];
    assign CNT    = r_cnt;

endmodule

// File: tb/tb_p405s_icu_dp_regpipe.sv
// Bench for p405s_icu_dp_regpipe: three parameterisations driven in lockstep and
// compared against a queue-of-words position model, plus directed scenarios on DEPTH=2.
module tb_p405s_icu_dp_regpipe;

    logic        cb = 1'b0;
    logic        rstl = 1'b0;
    logic        e1 = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] d = '0;

    always #5 cb = ~cb;

    logic [0:31] l2_0;
    logic [0:7]  l2_1;
    logic [0:63] l2_2;
    logic        vld0, vld1, vld2;
    logic        rdy0, rdy1, rdy2;
    logic [0:3]  cnt0;
    logic [0:1]  cnt1;
    logic [0:3]  cnt2;

    p405s_icu_dp_regpipe #(.WIDTH(32), .DEPTH(2), .CNTW(4)) u_dut0 (
        .CB(cb), .RSTL(rstl), .D(d[31:0]), .E1(e1), .IN_RDY(rdy0), .HOLD(hold),
        .FLUSH(flush), .L2(l2_0), .L2_VLD(vld0), .CNT(cnt0));

    p405s_icu_dp_regpipe #(.WIDTH(8), .DEPTH(1), .CNTW(2)) u_dut1 (
        .CB(cb), .RSTL(rstl), .D(d[7:0]), .E1(e1), .IN_RDY(rdy1), .HOLD(hold),
        .FLUSH(flush), .L2(l2_1), .L2_VLD(vld1), .CNT(cnt1));

    p405s_icu_dp_regpipe #(.WIDTH(64), .DEPTH(8), .CNTW(4)) u_dut2 (
        .CB(cb), .RSTL(rstl), .D(d), .E1(e1), .IN_RDY(rdy2), .HOLD(hold),
        .FLUSH(flush), .L2(l2_2), .L2_VLD(vld2), .CNT(cnt2));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: words in flight, oldest first, each tagged with its stage position.
    int          dep [3] = '{2, 1, 8};
    logic [63:0] msk [3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_00FF, {64{1'b1}}};
    logic [63:0] m_d [3][8];
    logic [63:0] n_d [3][8];
    int          m_p [3][8];
    int          n_p [3][8];
    int          m_n [3] = '{0, 0, 0};
    int          n_n [3];
    logic        e_rdy [3];

    function automatic logic [63:0] get_l2(input int n);
        case (n)
            0:       return 64'(l2_0);
            1:       return 64'(l2_1);
            default: return 64'(l2_2);
        endcase
    endfunction

    function automatic logic [63:0] get_vld(input int n);
        case (n)
            0:       return 64'(vld0);
            1:       return 64'(vld1);
            default: return 64'(vld2);
        endcase
    endfunction

    function automatic logic [63:0] get_rdy(input int n);
        case (n)
            0:       return 64'(rdy0);
            1:       return 64'(rdy1);
            default: return 64'(rdy2);
        endcase
    endfunction

    function automatic logic [63:0] get_cnt(input int n);
        case (n)
            0:       return 64'(cnt0);
            1:       return 64'(cnt1);
            default: return 64'(cnt2);
        endcase
    endfunction

    task automatic model_eval(input int n);
        int  nn;
        int  first;
        int  p;
        int  np;
        logic ret;
        logic slot0_free;
        nn  = 0;
        ret = (m_n[n] > 0) && (m_p[n][0] == dep[n] - 1) && !hold;
        first = ret ? 1 : 0;
        for (int i = first; i < m_n[n]; i++) begin
            p  = m_p[n][i];
            np = p;
            if (p < dep[n] - 1 && (nn == 0 || n_p[n][nn-1] != p + 1)) np = p + 1;
            n_p[n][nn] = np;
            n_d[n][nn] = m_d[n][i];
            nn++;
        end
        slot0_free = (nn == 0) || (n_p[n][nn-1] != 0);
        e_rdy[n]   = slot0_free && !flush;
        if (e1 && e_rdy[n]) begin
            n_p[n][nn] = 0;
            n_d[n][nn] = d & msk[n];
            nn++;
        end
        if (!rstl || flush) nn = 0;
        n_n[n] = nn;
    endtask

    // One clock: compare all instances against the model before the edge, then advance it.
    task automatic cycle();
        logic [63:0] x_l2;
        logic        x_vld;
        @(negedge cb);
        for (int n = 0; n < 3; n++) begin
            model_eval(n);
            x_vld = (m_n[n] > 0) && (m_p[n][0] == dep[n] - 1);
            x_l2  = x_vld ? m_d[n][0] : 64'h0;
            chk($sformatf("l2[%0d]", n), get_l2(n), x_l2);
            chk($sformatf("l2_vld[%0d]", n), get_vld(n), 64'(x_vld));
            chk($sformatf("cnt[%0d]", n), get_cnt(n), 64'(m_n[n]));
            if (rstl) chk($sformatf("in_rdy[%0d]", n), get_rdy(n), 64'(e_rdy[n]));
        end
        @(posedge cb);
        #1;
        for (int n = 0; n < 3; n++) begin
            m_n[n] = n_n[n];
            for (int i = 0; i < 8; i++) begin
                m_p[n][i] = n_p[n][i];
                m_d[n][i] = n_d[n][i];
            end
        end
    endtask

    initial begin
        int hmode;

        // Reset held with a write pending
        rstl = 1'b0; e1 = 1'b1; d = {64{1'b1}};
        @(posedge cb);
        #1;
        repeat (3) cycle();
        chk("rst_l2", 64'(l2_0), 64'h0);
        chk("rst_vld", 64'(vld0), 64'h0);
        chk("rst_cnt", 64'(cnt0), 64'h0);
        rstl = 1'b1; e1 = 1'b0; d = '0;
        #1;
        chk("rst_rdy", 64'(rdy0), 64'h1);

        // Back-to-back streaming
        for (int v = 1; v <= 5; v++) begin
            e1 = 1'b1; d = 64'(v);
            cycle();
            chk("stream_cnt", 64'(cnt0), (v == 1) ? 64'h1 : 64'h2);
            if (v >= 2) chk("stream_l2", 64'(l2_0), 64'(v - 1));
        end
        e1 = 1'b0;
        cycle();
        chk("stream_last", 64'(l2_0), 64'h5);
        cycle();
        chk("stream_empty", 64'(vld0), 64'h0);

        // Hold with bubble collapse, then release
        e1 = 1'b1; d = 64'hA5A5A5A5;
        cycle();
        e1 = 1'b0;
        cycle();
        chk("hold_a5", 64'(l2_0), 64'hA5A5A5A5);
        hold = 1'b1; e1 = 1'b1; d = 64'hB0;
        cycle();
        chk("hold_cnt", 64'(cnt0), 64'h2);
        chk("hold_rdy", 64'(rdy0), 64'h0);
        d = 64'hB1;
        cycle();
        chk("hold_stable", 64'(l2_0), 64'hA5A5A5A5);
        hold = 1'b0;
        cycle();
        chk("rel_b0", 64'(l2_0), 64'hB0);
        d = 64'hB2;
        cycle();
        chk("rel_b1", 64'(l2_0), 64'hB1);

        // Full pipe: retire and write in the same cycle
        d = 64'hC3;
        #1;
        chk("full_rdy", 64'(rdy0), 64'h1);
        cycle();
        chk("full_b2", 64'(l2_0), 64'hB2);
        chk("full_cnt", 64'(cnt0), 64'h2);
        e1 = 1'b0;
        cycle();
        chk("full_c3", 64'(l2_0), 64'hC3);

        // Flush while full and held
        hold = 1'b1; e1 = 1'b1; d = 64'hE0;
        cycle();
        flush = 1'b1; d = 64'hDEAD;
        #1;
        chk("flush_rdy", 64'(rdy0), 64'h0);
        cycle();
        chk("flush_cnt", 64'(cnt0), 64'h0);
        chk("flush_vld", 64'(vld0), 64'h0);
        chk("flush_l2", 64'(l2_0), 64'h0);
        flush = 1'b0; e1 = 1'b0; hold = 1'b0;
        repeat (3) cycle();

        // Reset together with flush while full
        hold = 1'b1; e1 = 1'b1; d = 64'h11;
        cycle();
        d = 64'h22;
        cycle();
        chk("pre_rst_cnt", 64'(cnt0), 64'h2);
        rstl = 1'b0; flush = 1'b1;
        cycle();
        chk("rstfl_cnt", 64'(cnt0), 64'h0);
        chk("rstfl_vld", 64'(vld0), 64'h0);
        chk("rstfl_l2", 64'(l2_0), 64'h0);
        rstl = 1'b1; flush = 1'b0; e1 = 1'b0; hold = 1'b0;
        cycle();

        // Random traffic with alternating light and heavy backpressure
        hmode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) hmode = int'($urandom_range(0, 2));
            rstl  = ($urandom_range(0, 249) != 0);
            flush = ($urandom_range(0, 49) == 0);
            e1    = ($urandom_range(0, 3) != 0);
            case (hmode)
                0:       hold = 1'b0;
                1:       hold = ($urandom_range(0, 3) == 0);
                default: hold = ($urandom_range(0, 7) != 0);
            endcase
            d = {$urandom(), $urandom()};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
